piso_serializer: RTL and testbench

Parallel-in/serial-out stage that feeds the bit-serial sequence detectors in the Lab-7 datapath. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on `dout`. The outputs qualify each bit and mark word boundaries, so the downstream detector and bench can align on frames. Back-to-back words stream with no idle gap.

---
 rtl/ser_pkg.sv | 17 +
 rtl/piso_serializer.sv | 136 +++++++++++++
 tb/tb_piso_serializer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the parallel-in/serial-out serializer.
//   SER_WIDTH_DEF : default word width in bits.
//   ser_state_t   : serializer state. It always has a 2-bit encoding, so
//                   PARITY keeps its code even in builds without the parity
//                   cycle.
`timescale 1ns/1ps
package ser_pkg;

  localparam int SER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: takes WIDTH-bit words over a valid/ready handshake and
// sends each one out MSB-first, one bit per clock. Back-to-back words stream
// with no idle cycle between them.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   data_in      in   parallel word, sampled only on an accepting edge
//   load_valid   in   upstream has a word on data_in
//   load_ready   out  combinational; the block can take a word this cycle
//   dout         out  serial bit; stays low while idle
//   dout_valid   out  dout carries a payload or parity bit
//   frame_start  out  high only while dout carries the MSB of a word
//   busy         out  copy of dout_valid
//
// Build option
//   SER_PARITY_EN : when defined, each word is followed by one even-parity
//                   bit, and load_ready moves from the LSB cycle to that
//                   parity cycle.
`timescale 1ns/1ps
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_frame_start;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif

  logic             w_load_ready;
  logic             w_accept;

  // Ready is high in the last output cycle of a word so that the next word
  // can follow with no gap. It is gated by reset so that it drops
  // immediately while reset is held.
  always_comb begin
    w_load_ready = 1'b0;
    if (reset) begin
      case (r_state)
        IDLE:    w_load_ready = 1'b1;
`ifdef SER_PARITY_EN
        PARITY:  w_load_ready = 1'b1;
`else
        SHIFT:   w_load_ready = (r_bit_cnt == CNT_W'(1));
`endif
        default: w_load_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = load_valid && w_load_ready;

  // The MSB goes straight to dout on the accepting edge. The shift register
  // therefore holds the remaining WIDTH-1 bits, left-justified.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_dout        <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      r_par         <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state       <= SHIFT;
      r_shreg       <= {data_in[WIDTH-2:0], 1'b0};
      r_bit_cnt     <= CNT_W'(WIDTH);
      r_dout        <= data_in[WIDTH-1];
      r_dout_valid  <= 1'b1;
      r_frame_start <= 1'b1;
`ifdef SER_PARITY_EN
      r_par         <= ^data_in;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          r_frame_start <= 1'b0;
          if (r_bit_cnt > CNT_W'(1)) begin
            r_dout    <= r_shreg[WIDTH-1];
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
          end else begin
`ifdef SER_PARITY_EN
            r_state      <= PARITY;
            r_dout       <= r_par;
            r_dout_valid <= 1'b1;
            r_bit_cnt    <= '0;
`else
            r_state      <= IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_bit_cnt    <= '0;
`endif
          end
        end
        default: begin
          // IDLE, the end of the parity cycle, and any unused encoding all
          // return to a quiet low line.
          r_state       <= IDLE;
          r_dout        <= 1'b0;
          r_dout_valid  <= 1'b0;
          r_frame_start <= 1'b0;
          r_bit_cnt     <= '0;
        end
      endcase
    end
  end

  assign load_ready  = w_load_ready;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_dout_valid;

endmodule

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
module tb_piso_serializer;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 8 + PAR;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       dout;
  logic       dout_valid;
  logic       frame_start;
  logic       busy;

  int tests_run;
  int tests_failed;

  piso_serializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; load_valid = 1'b1; data_in = 8'hFF;
    tick; tick;
    tests_run++;
    if ({dout, dout_valid, frame_start, busy, load_ready} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b want=00000", {dout, dout_valid, frame_start, busy, load_ready});
    end
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready got=%b want=1", load_ready);
    end
  endtask

  task automatic test_idle;
    for (int c = 0; c < 20; c++) begin
      tests_run++;
      if ({dout, dout_valid, load_ready} !== 3'b001) begin
        tests_failed++;
        $display("FAIL idle_line cyc=%0d got=%b want=001", c, {dout, dout_valid, load_ready});
      end
      tick;
    end
  endtask

  task automatic test_basic;
    logic [7:0] w;
    logic [3:0] exp;
    w = 8'hA5;
    data_in = w; load_valid = 1'b1;
    #1;
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_ready got=%b want=1", load_ready);
    end
    tick;
    load_valid = 1'b0; data_in = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      exp = {w[8-c], 1'b1, (c == 1), 1'b1};
      tests_run++;
      if ({dout, dout_valid, frame_start, busy} !== exp) begin
        tests_failed++;
        $display("FAIL basic_bit cyc=%0d got=%b want=%b", c, {dout, dout_valid, frame_start, busy}, exp);
      end
      tick;
    end
`ifdef SER_PARITY_EN
    tests_run++;
    if ({dout, dout_valid, frame_start} !== 3'b010) begin
      tests_failed++;
      $display("FAIL basic_parity got=%b want=010", {dout, dout_valid, frame_start});
    end
    tick;
`endif
    tests_run++;
    if ({dout, dout_valid, frame_start, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_after got=%b want=0000", {dout, dout_valid, frame_start, busy});
    end
  endtask

  task automatic test_back_to_back;
    logic [2*FL-1:0] got;
    logic [2*FL-1:0] exp_stream;
`ifdef SER_PARITY_EN
    exp_stream = {8'h0A, 1'b0, 8'hA0, 1'b0};
`else
    exp_stream = 16'b0000101010100000;
`endif
    got = '0;
    data_in = 8'h0A; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int c = 1; c <= 2*FL; c++) begin
      got[2*FL-c] = dout;
      tests_run++;
      if ({dout_valid, frame_start} !== {1'b1, (c == 1 || c == FL + 1)}) begin
        tests_failed++;
        $display("FAIL stream_flags cyc=%0d got=%b want=%b", c, {dout_valid, frame_start}, {1'b1, (c == 1 || c == FL + 1)});
      end
      if (c == FL) begin
        data_in = 8'hA0; load_valid = 1'b1;
        tests_run++;
        if (load_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_ready_last cyc=%0d got=%b want=1", c, load_ready);
        end
      end else if (c < FL) begin
        tests_run++;
        if (load_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_ready_busy cyc=%0d got=%b want=0", c, load_ready);
        end
      end
      tick;
      load_valid = 1'b0;
    end
    tests_run++;
    if (got !== exp_stream) begin
      tests_failed++;
      $display("FAIL stream_bits got=%b want=%b", got, exp_stream);
    end
    tests_run++;
    if ({dout, dout_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stream_after got=%b want=00", {dout, dout_valid});
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w0;
    logic [7:0] w1;
    w0 = 8'h3C; w1 = 8'h96;
    data_in = w0; load_valid = 1'b1;
    tick;
    for (int c = 1; c <= FL; c++) begin
      data_in = 8'h10 + 8'(c);
      if (c <= 8) begin
        tests_run++;
        if (dout !== w0[8-c]) begin
          tests_failed++;
          $display("FAIL bp_first_bit cyc=%0d got=%b want=%b", c, dout, w0[8-c]);
        end
      end
      if (c < FL) begin
        tests_run++;
        if (load_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_ready_low cyc=%0d got=%b want=0", c, load_ready);
        end
      end else begin
        data_in = w1;
        tests_run++;
        if (load_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_ready_high cyc=%0d got=%b want=1", c, load_ready);
        end
      end
      tick;
    end
    load_valid = 1'b0; data_in = 8'h00;
    for (int c = 1; c <= FL; c++) begin
      if (c <= 8) begin
        tests_run++;
        if ({dout, dout_valid} !== {w1[8-c], 1'b1}) begin
          tests_failed++;
          $display("FAIL bp_second_bit cyc=%0d got=%b want=%b", c, {dout, dout_valid}, {w1[8-c], 1'b1});
        end
      end
      tick;
    end
    tests_run++;
    if (dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_after got=%b want=0", dout_valid);
    end
  endtask

  task automatic test_reset_midword;
    data_in = 8'hFF; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tests_run++;
      if ({dout, dout_valid} !== 2'b11) begin
        tests_failed++;
        $display("FAIL rst_pre_bit cyc=%0d got=%b want=11", c, {dout, dout_valid});
      end
      tick;
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dout, dout_valid, frame_start, busy, load_ready} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL rst_async got=%b want=00000", {dout, dout_valid, frame_start, busy, load_ready});
    end
    tick; tick;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      tests_run++;
      if ({dout, dout_valid, frame_start, load_ready} !== 4'b0001) begin
        tests_failed++;
        $display("FAIL rst_after cyc=%0d got=%b want=0001", c, {dout, dout_valid, frame_start, load_ready});
      end
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       pbit  [2];
    words[0] = 8'h07; pbit[0] = 1'b1;
    words[1] = 8'h03; pbit[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_in = words[k]; load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        tests_run++;
        if (load_ready !== (c == 9)) begin
          tests_failed++;
          $display("FAIL par_ready w=%0d cyc=%0d got=%b want=%b", k, c, load_ready, (c == 9));
        end
        if (c == 9) begin
          tests_run++;
          if ({dout, dout_valid, frame_start} !== {pbit[k], 2'b10}) begin
            tests_failed++;
            $display("FAIL par_bit w=%0d got=%b want=%b", k, {dout, dout_valid, frame_start}, {pbit[k], 2'b10});
          end
        end
        tick;
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    load_valid = 1'b0;
    data_in = 8'h00;
    test_reset;
    test_idle;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_reset_midword;
`ifdef SER_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
